// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/freeze strobes for the
// 5-stage core, memory watchdog and stall/flush performance counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_memRead,
  input  logic             mem_memWrite,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_cnt_nxt;

  logic mem_acc;
  logic load_use;
  logic frozen;
  logic redirect;
  logic lu_stall;

  assign mem_acc = mem_memRead | mem_memWrite;

  assign load_use = ex_memRead && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    frozen = 1'b0;
    unique case (state)
      RUN:      frozen = mem_acc & ~dmem_ready;
      MEM_WAIT: frozen = ~dmem_ready;
      ERROR:    frozen = 1'b1;
      default:  frozen = 1'b1;
    endcase
  end

  // Redirect kills the load-use consumer, so it wins over the stall.
  assign redirect = ~frozen & ex_redirect;
  assign lu_stall = ~frozen & ~ex_redirect & load_use;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    dmem_req    = mem_acc && (state != ERROR);
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      dmem_req    = 1'b0;
    end else begin
      unique case (1'b1)
        frozen: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end
        redirect: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        lu_stall: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_acc && !dmem_ready) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt == LAST) begin
          state_nxt = ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= (state_nxt == ERROR);
    end
  end

  // Counters freeze in ERROR and saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (state != ERROR) begin
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (redirect && (flush_events != '1))
        flush_events <= flush_events + 1'b1;
    end
  end

endmodule
